// File: rtl/program_loader.sv
// Program loader: streams a byte program into instruction memory, verifies an XOR
// checksum and holds the CPU in reset until a fully written, verified image is present.
module program_loader #(
    parameter int DEPTH = 32
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_load_start,
    input  logic [7:0] i_load_len,
    input  logic       i_in_valid,
    input  logic [7:0] i_in_data,
    output logic       o_in_ready,
    output logic       o_mem_we,
    output logic [7:0] o_mem_addr,
    output logic [7:0] o_mem_wdata,
    output logic       o_cpu_reset,
    output logic       o_done,
    output logic       o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_t;

    state_t     r_state, w_state_next;
    logic [7:0] r_count, w_count_next;
    logic [7:0] r_len, w_len_next;
    logic [7:0] r_csum, w_csum_next;
    logic       r_mem_we, w_mem_we_next;
    logic [7:0] r_mem_addr, w_mem_addr_next;
    logic [7:0] r_mem_wdata, w_mem_wdata_next;
    logic       r_cpu_reset, r_done, r_err;
    logic       w_in_ready, w_beat, w_len_ok, w_last_beat;

    assign w_in_ready  = (r_state == S_LOAD) || (r_state == S_CHECK);
    assign w_beat      = i_in_valid && w_in_ready;
    assign w_len_ok    = (i_load_len != 8'd0) && ({1'b0, i_load_len} <= 9'(DEPTH));
    // Widened compare so the final-beat test cannot alias when count increments.
    assign w_last_beat = ({1'b0, r_count} + 9'd1) == {1'b0, r_len};

    always_comb begin
        w_state_next     = r_state;
        w_count_next     = r_count;
        w_len_next       = r_len;
        w_csum_next      = r_csum;
        w_mem_we_next    = 1'b0;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;
        case (r_state)
            S_IDLE, S_RUN, S_ERROR: begin
                if (i_load_start) begin
                    if (w_len_ok) begin
                        w_state_next = S_LOAD;
                        w_len_next   = i_load_len;
                        w_count_next = 8'd0;
                        w_csum_next  = 8'd0;
                    end else begin
                        w_state_next = S_ERROR;
                    end
                end
            end
            S_LOAD: begin
                if (w_beat) begin
                    w_mem_we_next    = 1'b1;
                    w_mem_addr_next  = r_count;
                    w_mem_wdata_next = i_in_data;
                    w_csum_next      = r_csum ^ i_in_data;
                    w_count_next     = r_count + 8'd1;
                    if (w_last_beat) begin
                        w_state_next = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (w_beat) begin
                    w_state_next = (i_in_data == r_csum) ? S_RUN : S_ERROR;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Status flags are derived from the next state so they move on the transition edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_count     <= 8'd0;
            r_len       <= 8'd0;
            r_csum      <= 8'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 8'd0;
            r_mem_wdata <= 8'd0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_count     <= w_count_next;
            r_len       <= w_len_next;
            r_csum      <= w_csum_next;
            r_mem_we    <= w_mem_we_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_cpu_reset <= (w_state_next != S_RUN);
            r_done      <= (w_state_next == S_RUN);
            r_err       <= (w_state_next == S_ERROR);
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_cpu_reset = r_cpu_reset;
    assign o_done      = r_done;
    assign o_err       = r_err;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: nominal, bad checksum, illegal lengths, stalls,
// reload/retry, full-depth load and asynchronous reset in the middle of a load.
module tb_program_loader;

    localparam int DEPTH = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_start = 1'b0;
    logic [7:0] load_len = 8'd0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_ready, mem_we, cpu_reset, done, err;
    logic [7:0] mem_addr, mem_wdata;

    int n_cmp = 0;
    int n_bad = 0;

    program_loader #(.DEPTH(DEPTH)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_load_start(load_start),
        .i_load_len  (load_len),
        .i_in_valid  (in_valid),
        .i_in_data   (in_data),
        .o_in_ready  (in_ready),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_cpu_reset (cpu_reset),
        .o_done      (done),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic status(input string tag, input logic rdy, input logic crst,
                          input logic dn, input logic er);
        chk({tag, ".in_ready"}, 9'(in_ready), 9'(rdy));
        chk({tag, ".cpu_reset"}, 9'(cpu_reset), 9'(crst));
        chk({tag, ".done"}, 9'(done), 9'(dn));
        chk({tag, ".err"}, 9'(err), 9'(er));
    endtask

    task automatic start(input logic [7:0] len);
        load_start = 1'b1;
        load_len   = len;
        tick();
        load_start = 1'b0;
    endtask

    // One data beat; the registered write must appear right after the accepting edge.
    task automatic data_beat(input string tag, input logic [7:0] d, input logic [7:0] a);
        chk({tag, ".ready_before"}, 9'(in_ready), 9'd1);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        chk({tag, ".we"}, 9'(mem_we), 9'd1);
        chk({tag, ".addr"}, 9'(mem_addr), 9'(a));
        chk({tag, ".wdata"}, 9'(mem_wdata), 9'(d));
        chk({tag, ".cpu_reset"}, 9'(cpu_reset), 9'd1);
    endtask

    task automatic gap(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, ".gap_we"}, 9'(mem_we), 9'd0);
            chk({tag, ".gap_ready"}, 9'(in_ready), 9'd1);
        end
    endtask

    task automatic csum_beat(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        chk("csum.we", 9'(mem_we), 9'd0);
    endtask

    // Program 0x41,0x82,0x05 -> XOR checksum 0xC6.
    task automatic load3(input string tag, input int gaps, input logic [7:0] cs);
        start(8'd3);
        status({tag, ".start"}, 1'b1, 1'b1, 1'b0, 1'b0);
        data_beat({tag, ".b0"}, 8'h41, 8'h00);
        gap(tag, gaps);
        data_beat({tag, ".b1"}, 8'h82, 8'h01);
        gap(tag, gaps);
        data_beat({tag, ".b2"}, 8'h05, 8'h02);
        gap(tag, gaps);
        csum_beat(cs);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] cs;
        logic [7:0] b;

        // Reset values
        tick();
        tick();
        status("reset", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("reset.we", 9'(mem_we), 9'd0);
        chk("reset.addr", 9'(mem_addr), 9'd0);
        chk("reset.wdata", 9'(mem_wdata), 9'd0);
        rst = 1'b0;

        // Nominal load
        load3("nominal", 0, 8'hC6);
        status("nominal.end", 1'b0, 1'b0, 1'b1, 1'b0);

        // Bad checksum from RUN: Cpu_Reset rises at start edge
        load3("badcs", 0, 8'h00);
        status("badcs.end", 1'b0, 1'b1, 1'b0, 1'b1);

        // Illegal lengths from IDLE, with In_Valid high throughout
        do_reset();
        in_valid = 1'b1;
        in_data  = 8'hAA;
        start(8'd0);
        status("len0", 1'b0, 1'b1, 1'b0, 1'b1);
        chk("len0.we", 9'(mem_we), 9'd0);
        do_reset();
        start(8'(DEPTH + 1));
        status("len33", 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        chk("len33.we", 9'(mem_we), 9'd0);
        chk("len33.ready", 9'(in_ready), 9'd0);
        in_valid = 1'b0;

        // Stalled stream, started from ERROR (Err clears on start edge)
        load3("stall", 2, 8'hC6);
        status("stall.end", 1'b0, 1'b0, 1'b1, 1'b0);

        // Reload from RUN with a single byte
        start(8'd1);
        status("reload.start", 1'b1, 1'b1, 1'b0, 1'b0);
        data_beat("reload.b0", 8'h7F, 8'h00);
        csum_beat(8'h7F);
        status("reload.end", 1'b0, 1'b0, 1'b1, 1'b0);

        // Fail then retry from ERROR
        start(8'd1);
        data_beat("retry.bad", 8'h7F, 8'h00);
        csum_beat(8'h00);
        status("retry.err", 1'b0, 1'b1, 1'b0, 1'b1);
        start(8'd1);
        status("retry.start", 1'b1, 1'b1, 1'b0, 1'b0);
        data_beat("retry.b0", 8'h7F, 8'h00);
        csum_beat(8'h7F);
        status("retry.end", 1'b0, 1'b0, 1'b1, 1'b0);

        // Full-depth load: addresses 0..DEPTH-1
        cs = 8'h00;
        start(8'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            b  = 8'((i * 7 + 3) & 8'hFF);
            cs = cs ^ b;
            data_beat("depth", b, 8'(i));
        end
        chk("depth.check_state", 9'(in_ready), 9'd1);
        csum_beat(cs);
        status("depth.end", 1'b0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset after the first of three beats
        start(8'd3);
        data_beat("midrst.b0", 8'h41, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        status("midrst.async", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("midrst.we", 9'(mem_we), 9'd0);
        chk("midrst.addr", 9'(mem_addr), 9'd0);
        in_valid = 1'b1;
        in_data  = 8'h82;
        tick();
        chk("midrst.held_we", 9'(mem_we), 9'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        status("midrst.idle", 1'b0, 1'b1, 1'b0, 1'b0);
        load3("after", 0, 8'hC6);
        status("after.end", 1'b0, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
